// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction fetch stage: FSM states, fault causes
// and the reset instruction.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_STATE_IDLE = 2'd0,
    FETCH_STATE_BUS  = 2'd1,
    FETCH_STATE_HOLD = 2'd2,
    FETCH_STATE_TRAP = 2'd3
  } fetch_state_e;

  localparam logic [1:0] FETCH_CAUSE_NONE       = 2'd0;
  localparam logic [1:0] FETCH_CAUSE_MISALIGNED = 2'd1;
  localparam logic [1:0] FETCH_CAUSE_BUSERR     = 2'd2;
  localparam logic [1:0] FETCH_CAUSE_TIMEOUT    = 2'd3;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_timer.sv
// Bus wait-cycle counter for the fetch stage; flags expiry when the count
// equals TIMEOUT. A TIMEOUT of 0 never expires.
module fetch_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic I_clk,
  input  logic I_reset_n,
  input  logic I_clr,
  input  logic I_en,
  output logic O_expired
);

  localparam int unsigned CW = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (I_clr) begin
      cnt_d = '0;
    end else if (I_en) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign O_expired = (TIMEOUT != 32'd0) && (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one Wishbone read per request, holds the
// instruction and its PC for the decoder, and reports fetch faults.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_fetch_req,
  input  logic        I_pc_load,
  input  logic [31:0] I_next_pc,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_instr_valid,
  output logic        O_busy,
  output logic        O_trap,
  output logic [1:0]  O_trap_cause,
  output logic [31:0] O_bus_addr,
  output logic        O_bus_cyc,
  output logic        O_bus_stb,
  input  logic [31:0] I_bus_data,
  input  logic        I_bus_ack,
  input  logic        I_bus_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  seq_pc_q, seq_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         trap_q, trap_d;
  logic [1:0]   cause_q, cause_d;
  logic [31:0]  addr_q, addr_d;
  logic         cyc_q, cyc_d;

  logic [31:0]  target;
  logic         timer_clr, timer_en, timer_expired;

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .I_clk     (I_clk),
    .I_reset_n (I_reset_n),
    .I_clr     (timer_clr),
    .I_en      (timer_en),
    .O_expired (timer_expired)
  );

  // Next-state and output-register logic of the fetch FSM.
  always_comb begin
    state_d   = state_q;
    seq_pc_d  = seq_pc_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    addr_d    = addr_q;
    cyc_d     = cyc_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    target    = I_pc_load ? I_next_pc : seq_pc_q;

    case (state_q)
      FETCH_STATE_IDLE, FETCH_STATE_HOLD, FETCH_STATE_TRAP: begin
        if (I_fetch_req) begin
          valid_d = 1'b0;
          trap_d  = 1'b0;
          cause_d = FETCH_CAUSE_NONE;
          if (!is_word_aligned(target)) begin
            state_d = FETCH_STATE_TRAP;
            trap_d  = 1'b1;
            cause_d = FETCH_CAUSE_MISALIGNED;
            pc_d    = target;
          end else begin
            state_d   = FETCH_STATE_BUS;
            addr_d    = target;
            cyc_d     = 1'b1;
            busy_d    = 1'b1;
            timer_clr = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      FETCH_STATE_BUS: begin
        // Error wins over a simultaneous ack; every exit drops cyc/stb.
        if (I_bus_err) begin
          state_d = FETCH_STATE_TRAP;
          trap_d  = 1'b1;
          cause_d = FETCH_CAUSE_BUSERR;
          pc_d    = addr_q;
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (I_bus_ack) begin
          state_d  = FETCH_STATE_HOLD;
          instr_d  = I_bus_data;
          pc_d     = addr_q;
          valid_d  = 1'b1;
          seq_pc_d = addr_q + 32'd4;
          cyc_d    = 1'b0;
          busy_d   = 1'b0;
        end else if (timer_expired) begin
          state_d = FETCH_STATE_TRAP;
          trap_d  = 1'b1;
          cause_d = FETCH_CAUSE_TIMEOUT;
          pc_d    = addr_q;
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        state_d = FETCH_STATE_IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q  <= FETCH_STATE_IDLE;
      seq_pc_q <= RESET_PC;
      instr_q  <= INSTR_NOP;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      trap_q   <= 1'b0;
      cause_q  <= FETCH_CAUSE_NONE;
      addr_q   <= 32'h0000_0000;
      cyc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_pc_q <= seq_pc_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
      addr_q   <= addr_d;
      cyc_q    <= cyc_d;
    end
  end

  assign O_instr       = instr_q;
  assign O_pc          = pc_q;
  assign O_instr_valid = valid_q;
  assign O_busy        = busy_q;
  assign O_trap        = trap_q;
  assign O_trap_cause  = cause_q;
  assign O_bus_addr    = addr_q;
  assign O_bus_cyc     = cyc_q;
  assign O_bus_stb     = cyc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetches push expected results,
// a negedge monitor pops and compares whenever a fetch result appears.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        I_fetch_req, I_pc_load;
  logic [31:0] I_next_pc;
  logic [31:0] O_instr, O_pc, O_bus_addr;
  logic        O_instr_valid, O_busy, O_trap, O_bus_cyc, O_bus_stb;
  logic [1:0]  O_trap_cause;
  logic [31:0] I_bus_data;
  logic        I_bus_ack, I_bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        valid;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [31:0] instr;
  } resp_t;

  resp_t exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .I_clk(clk), .I_reset_n(rst_n),
    .I_fetch_req(I_fetch_req), .I_pc_load(I_pc_load), .I_next_pc(I_next_pc),
    .O_instr(O_instr), .O_pc(O_pc), .O_instr_valid(O_instr_valid),
    .O_busy(O_busy), .O_trap(O_trap), .O_trap_cause(O_trap_cause),
    .O_bus_addr(O_bus_addr), .O_bus_cyc(O_bus_cyc), .O_bus_stb(O_bus_stb),
    .I_bus_data(I_bus_data), .I_bus_ack(I_bus_ack), .I_bus_err(I_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: a result is new when the bus just finished or the visible tuple changed.
  logic [35:0] prev_tup;
  logic        prev_busy;
  always @(negedge clk) begin
    automatic logic [35:0] cur = {O_instr_valid, O_trap, O_trap_cause, O_pc};
    automatic resp_t e;
    if (rst_n && (O_instr_valid || O_trap) && !O_busy && (prev_busy || cur !== prev_tup)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got pc %h valid %b trap %b, none expected", O_pc, O_instr_valid, O_trap);
      end else begin
        e = exp_q.pop_front();
        check("sb_valid", 32'(O_instr_valid), 32'(e.valid));
        check("sb_trap", 32'(O_trap), 32'(e.trap));
        check("sb_cause", 32'(O_trap_cause), 32'(e.cause));
        check("sb_pc", O_pc, e.pc);
        if (e.valid) check("sb_instr", O_instr, e.instr);
      end
    end
    prev_tup  <= cur;
    prev_busy <= O_busy;
  end

  task automatic push(input logic v, input logic t, input logic [1:0] c,
                      input logic [31:0] pc, input logic [31:0] ins);
    resp_t r;
    r.valid = v; r.trap = t; r.cause = c; r.pc = pc; r.instr = ins;
    exp_q.push_back(r);
  endtask

  task automatic issue(input logic load, input logic [31:0] npc);
    @(negedge clk);
    I_fetch_req = 1'b1; I_pc_load = load; I_next_pc = npc;
    @(negedge clk);
    I_fetch_req = 1'b0; I_pc_load = 1'b0;
  endtask

  task automatic bus_reply(input string tag, input logic [31:0] exp_addr, input int waits,
                           input logic ack, input logic err, input logic [31:0] data);
    check({tag, "_cyc"}, 32'(O_bus_cyc), 32'd1);
    check({tag, "_stb"}, 32'(O_bus_stb), 32'd1);
    check({tag, "_addr"}, O_bus_addr, exp_addr);
    repeat (waits) @(negedge clk);
    I_bus_ack = ack; I_bus_err = err; I_bus_data = data;
    @(negedge clk);
    I_bus_ack = 1'b0; I_bus_err = 1'b0;
    check({tag, "_cyc_drop"}, 32'(O_bus_cyc), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    I_fetch_req = 1'b0; I_pc_load = 1'b0; I_next_pc = 32'h0;
    I_bus_data = 32'h0; I_bus_ack = 1'b0; I_bus_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_instr", O_instr, 32'h0000_0013);
    check("rst_pc", O_pc, 32'h0);
    check("rst_valid", 32'(O_instr_valid), 32'd0);
    check("rst_busy", 32'(O_busy), 32'd0);
    check("rst_trap", 32'(O_trap), 32'd0);
    check("rst_cause", 32'(O_trap_cause), 32'd0);
    check("rst_addr", O_bus_addr, 32'h0);
    check("rst_cyc", 32'(O_bus_cyc | O_bus_stb), 32'd0);

    // Sequential fetch from reset PC, two wait states.
    push(1'b1, 1'b0, 2'd0, 32'h0, 32'h0010_0093);
    issue(1'b0, 32'h0);
    bus_reply("f0", 32'h0, 2, 1'b1, 1'b0, 32'h0010_0093);

    // Next sequential fetch at 4, zero wait states.
    push(1'b1, 1'b0, 2'd0, 32'h4, 32'h0020_0113);
    issue(1'b0, 32'h0);
    bus_reply("f4", 32'h4, 0, 1'b1, 1'b0, 32'h0020_0113);

    // Misaligned redirect: trap without any bus cycle.
    push(1'b0, 1'b1, 2'd1, 32'h0000_0102, 32'h0);
    issue(1'b1, 32'h0000_0102);
    for (int i = 0; i < 3; i++) begin
      check("mis_no_cyc", 32'(O_bus_cyc), 32'd0);
      @(negedge clk);
    end

    // Ack and err together: error wins; seq_pc still 8 after the fault above.
    push(1'b0, 1'b1, 2'd2, 32'h8, 32'h0);
    issue(1'b0, 32'h0);
    bus_reply("err", 32'h8, 1, 1'b1, 1'b1, 32'hDEAD_BEEF);

    // Silent slave: timeout after TIMEOUT+1 = 5 strobe cycles.
    push(1'b0, 1'b1, 2'd3, 32'h8, 32'h0);
    issue(1'b0, 32'h0);
    check("to_addr", O_bus_addr, 32'h8);
    n = 0;
    while (O_bus_cyc && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("to_stb_cycles", 32'(n), 32'd5);
    check("to_cyc_drop", 32'(O_bus_stb), 32'd0);

    // Redirect to the last word, then wrap to 0.
    push(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFC, 32'h0030_0193);
    issue(1'b1, 32'hFFFF_FFFC);
    bus_reply("top", 32'hFFFF_FFFC, 0, 1'b1, 1'b0, 32'h0030_0193);
    push(1'b1, 1'b0, 2'd0, 32'h0, 32'h0040_0213);
    issue(1'b0, 32'h0);
    bus_reply("wrap", 32'h0, 1, 1'b1, 1'b0, 32'h0040_0213);

    // Reset in the middle of a bus cycle, then a late ack.
    issue(1'b0, 32'h0);
    check("rb_cyc", 32'(O_bus_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rb_async_cyc", 32'(O_bus_cyc | O_bus_stb), 32'd0);
    check("rb_busy", 32'(O_busy), 32'd0);
    check("rb_instr", O_instr, 32'h0000_0013);
    check("rb_valid", 32'(O_instr_valid), 32'd0);
    check("rb_addr", O_bus_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    I_bus_ack = 1'b1; I_bus_data = 32'hCAFE_F00D;
    @(negedge clk);
    I_bus_ack = 1'b0;
    @(negedge clk);
    check("late_ack_valid", 32'(O_instr_valid), 32'd0);
    check("late_ack_instr", O_instr, 32'h0000_0013);
    check("late_ack_cyc", 32'(O_bus_cyc), 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multi-cycle RV32 core. On request from the control unit it fetches one 32-bit instruction over the Wishbone-style instruction bus and holds it, with its PC, on stable outputs that feed the decoder's instruction input. It tracks the sequential fetch address, accepts redirects from the execute stage, and reports fetch faults (misaligned target, bus error, timeout) to the trap logic.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- TIMEOUT, 255: maximum wait cycles for ack/err per bus cycle; 0 disables the timeout.

Clock is I_clk; reset is I_reset_n, asynchronous, active-low.

- I_clk  in  1  core clock.
- I_reset_n  in  1  asynchronous active-low reset.
- I_fetch_req  in  1  start a fetch; sampled in IDLE, HOLD and TRAP only.
- I_pc_load  in  1  with I_fetch_req, fetch from I_next_pc instead of the sequential address.
- I_next_pc  in  32  redirect target (jump/branch/trap vector).
- O_instr  out  32  held instruction, to the decoder.
- O_pc  out  32  address of O_instr, or of the faulting fetch.
- O_instr_valid  out  1  O_instr holds a successfully fetched instruction.
- O_busy  out  1  bus cycle in progress.
- O_trap  out  1  fetch fault held.
- O_trap_cause  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout.
- O_bus_addr  out  32  bus address, word-aligned.
- O_bus_cyc, O_bus_stb  out  1 each  bus cycle and strobe, always driven equal.
- I_bus_data  in  32  read data, valid with I_bus_ack.
- I_bus_ack  in  1  cycle completed with data.
- I_bus_err  in  1  cycle terminated with error.

## Operation
- State is held in `seq_pc`, the next sequential address, plus an FSM with states IDLE, BUS, HOLD and TRAP.
- Reset values:
  - state IDLE; `seq_pc` = RESET_PC.
  - O_instr = 32'h0000_0013 (NOP); O_pc = RESET_PC.
  - O_instr_valid, O_busy, O_trap, O_bus_cyc and O_bus_stb all 0; O_trap_cause 0; O_bus_addr 0.
- IDLE/HOLD/TRAP with I_fetch_req=1:
  - Target = I_pc_load ? I_next_pc : `seq_pc`.
  - O_instr_valid, O_trap and O_trap_cause clear.
  - If target[1:0]≠0: go to TRAP with cause 1 and O_pc = target. No bus cycle is issued.
  - Otherwise: go to BUS with O_bus_addr = target, cyc/stb = 1 and the timer cleared.
- BUS:
  - O_busy = 1, and I_fetch_req is ignored.
  - I_bus_err (takes priority over ack): go to TRAP with cause 2; O_pc = O_bus_addr.
  - Else I_bus_ack: O_instr = I_bus_data, O_pc = O_bus_addr, O_instr_valid = 1, `seq_pc` = O_bus_addr + 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0); go to HOLD.
  - Else, when TIMEOUT≠0 and the timer reaches TIMEOUT: go to TRAP with cause 3.
  - Every exit from BUS drops cyc/stb on the same edge.
- HOLD/TRAP: outputs stay stable until the next accepted I_fetch_req.
- A fault does not advance `seq_pc`.
- An ack or err arriving while not in BUS is ignored.

## Timing
- I_fetch_req sampled at edge N → cyc/stb high after N.
- Ack may be combinational. If ack is sampled at edge N+k (k≥1), O_instr_valid rises after N+k.
  - Minimum latency: request to valid = 2 edges.
- Timer counts the cycles in BUS without ack/err. Cause 3 is raised at the edge where the count reaches TIMEOUT, i.e. after TIMEOUT+1 cycles of stb.
- Reset asserted mid-cycle drops cyc/stb immediately (asynchronously). A late ack after reset release is ignored (state is IDLE).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- cpu/cpudefs.vh gains:
  - FETCH_CAUSE_NONE, FETCH_CAUSE_MISALIGNED, FETCH_CAUSE_BUSERR, FETCH_CAUSE_TIMEOUT.
  - FETCH_STATE_* encodings.
  - INSTR_NOP (32'h0000_0013).
- One sub-module, `fetch_timer`: a clear/enable/compare counter sized $clog2(TIMEOUT+1), with its compare output tied off when TIMEOUT=0.
- The FSM, `seq_pc` and the output registers live in fetch_unit.

## Test plan
- Reset, then fetch_req with pc_load=0, slave acks 32'h0010_0093 after 2 wait cycles → O_pc=0, O_instr=32'h0010_0093, valid; the next sequential fetch addresses 4.
- fetch_req with pc_load=1, next_pc=32'h0000_0102 → TRAP cause 1, O_pc=32'h102, cyc never asserted; the following fetch still uses the old `seq_pc`.
- Slave asserts ack and err in the same cycle → cause 2, valid 0, O_pc = bus address.
- TIMEOUT=4, silent slave → cause 3 after exactly 5 stb cycles, cyc/stb drop on that edge.
- Redirect to 32'hFFFF_FFFC, ack, then sequential fetch → bus address 0.
- Assert I_reset_n low during BUS, then ack after release → cyc/stb 0 asynchronously, outputs at reset values, ack ignored.
